// File: rtl/branch_pc_unit_if.sv
// ---------------------------------------------------------------------------
// branch_pc_unit_if
// Groups every non-clock/reset signal of the branch/PC stage into one bundle.
//
// Signals (driven by the upstream pipeline / comparator / trap handler):
//   instr_valid, stall, br_en, jal, jalr, funct3, brEq, brLT, alu_target,
//   trap_ack
// Signals (driven by branch_pc_unit):
//   brUn, pc, pc_plus4, taken, trap, trap_pc, br_count, taken_count
//
// Modports:
//   master - the surrounding pipeline (drives inputs, observes results)
//   slave  - branch_pc_unit itself
// ---------------------------------------------------------------------------
interface branch_pc_unit_if #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
);
    logic             instr_valid;
    logic             stall;
    logic             br_en;
    logic             jal;
    logic             jalr;
    logic [2:0]       funct3;
    logic             brEq;
    logic             brLT;
    logic [WIDTH-1:0] alu_target;
    logic             trap_ack;

    logic             brUn;
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] pc_plus4;
    logic             taken;
    logic             trap;
    logic [WIDTH-1:0] trap_pc;
    logic [CNT_W-1:0] br_count;
    logic [CNT_W-1:0] taken_count;

    modport master (
        output instr_valid, stall, br_en, jal, jalr, funct3, brEq, brLT,
               alu_target, trap_ack,
        input  brUn, pc, pc_plus4, taken, trap, trap_pc, br_count, taken_count
    );

    modport slave (
        input  instr_valid, stall, br_en, jal, jalr, funct3, brEq, brLT,
               alu_target, trap_ack,
        output brUn, pc, pc_plus4, taken, trap, trap_pc, br_count, taken_count
    );
endinterface

// File: rtl/branch_pc_unit.sv
// ---------------------------------------------------------------------------
// branch_pc_unit
// Branch resolution and program-counter stage sitting right after the branch
// comparator. It tells the comparator whether to compare unsigned (brUn),
// turns brEq/brLT into a taken decision, owns the architectural PC and picks
// the next PC (sequential, branch, JAL or JALR target). Misaligned
// control-flow targets raise a trap that holds the stage until the handler
// acknowledges it; saturating counters track retired and taken branches.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-high reset
//   bus (slave)  instr_valid, stall, br_en, jal, jalr, funct3, brEq, brLT,
//                alu_target, trap_ack in;
//                brUn, pc, pc_plus4, taken, trap, trap_pc, br_count,
//                taken_count out
// ---------------------------------------------------------------------------
module branch_pc_unit #(
    parameter int              WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = 32'h0000_0000,
    parameter logic [WIDTH-1:0] TRAP_VEC = 32'h0000_0100,
    parameter int              CNT_W    = 16
) (
    input  logic               clk,
    input  logic               rst,
    branch_pc_unit_if.slave    bus
);

    typedef enum logic [0:0] {
        RUN  = 1'b0,
        TRAP = 1'b1
    } state_t;

    // Saturating increment: all-ones stays all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (&v) begin
            return v;
        end else begin
            return v + CNT_W'(1'b1);
        end
    endfunction

    state_t           state_r;
    state_t           state_s;
    logic [WIDTH-1:0] pc_r;
    logic [WIDTH-1:0] pc_s;
    logic             trap_r;
    logic             trap_s;
    logic [WIDTH-1:0] trap_pc_r;
    logic [WIDTH-1:0] trap_pc_s;
    logic [CNT_W-1:0] br_count_r;
    logic [CNT_W-1:0] br_count_s;
    logic [CNT_W-1:0] taken_count_r;
    logic [CNT_W-1:0] taken_count_s;

    logic             br_cond_s;
    logic             taken_s;
    logic [WIDTH-1:0] target_s;
    logic [WIDTH-1:0] pc_plus4_s;
    logic             advance_s;
    logic             misaligned_s;
    logic             cond_branch_s;

    // Sequential return address; wraps naturally modulo 2^WIDTH.
    assign pc_plus4_s = pc_r + WIDTH'(32'd4);

    // Branch condition decode from funct3 and the comparator flags.
    always_comb begin
        br_cond_s = 1'b0;
        case (bus.funct3)
            3'b000:  br_cond_s = bus.brEq;
            3'b001:  br_cond_s = !bus.brEq;
            3'b100:  br_cond_s = bus.brLT;
            3'b110:  br_cond_s = bus.brLT;
            3'b101:  br_cond_s = !bus.brLT;
            3'b111:  br_cond_s = !bus.brLT;
            default: br_cond_s = 1'b0;
        endcase
    end

    // Control-transfer decision and target selection; jalr outranks jal,
    // which outranks a conditional branch. JALR drops bit 0 of its target.
    always_comb begin
        taken_s       = 1'b0;
        target_s      = bus.alu_target;
        cond_branch_s = 1'b0;
        if (bus.jalr) begin
            taken_s  = 1'b1;
            target_s = {bus.alu_target[WIDTH-1:1], 1'b0};
        end else if (bus.jal) begin
            taken_s  = 1'b1;
            target_s = bus.alu_target;
        end else if (bus.br_en) begin
            taken_s       = br_cond_s;
            target_s      = bus.alu_target;
            cond_branch_s = 1'b1;
        end else begin
            taken_s  = 1'b0;
            target_s = bus.alu_target;
        end
    end

    // An instruction only retires in RUN with valid set and no stall; the
    // alignment check is meaningful only for such a qualified advance.
    assign advance_s    = (state_r == RUN) && bus.instr_valid && !bus.stall;
    assign misaligned_s = advance_s && taken_s && target_s[1];

    // Next-state / next-register computation for the RUN/TRAP machine.
    always_comb begin
        state_s       = state_r;
        pc_s          = pc_r;
        trap_s        = trap_r;
        trap_pc_s     = trap_pc_r;
        br_count_s    = br_count_r;
        taken_count_s = taken_count_r;
        case (state_r)
            RUN: begin
                if (misaligned_s) begin
                    // Faulting instruction does not retire: PC and counters hold.
                    trap_s    = 1'b1;
                    trap_pc_s = pc_r;
                    state_s   = TRAP;
                end else if (advance_s) begin
                    pc_s = taken_s ? target_s : pc_plus4_s;
                    if (cond_branch_s) begin
                        br_count_s = sat_inc(br_count_r);
                        if (taken_s) begin
                            taken_count_s = sat_inc(taken_count_r);
                        end else begin
                            taken_count_s = taken_count_r;
                        end
                    end else begin
                        br_count_s = br_count_r;
                    end
                end else begin
                    pc_s = pc_r;
                end
            end
            TRAP: begin
                // All pipeline inputs are ignored here; only the ack matters.
                if (bus.trap_ack) begin
                    pc_s    = TRAP_VEC;
                    trap_s  = 1'b0;
                    state_s = RUN;
                end else begin
                    state_s = TRAP;
                end
            end
            default: begin
                state_s = RUN;
                trap_s  = 1'b0;
            end
        endcase
    end

    // State and architectural registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r       <= RUN;
            pc_r          <= RESET_PC;
            trap_r        <= 1'b0;
            trap_pc_r     <= '0;
            br_count_r    <= '0;
            taken_count_r <= '0;
        end else begin
            state_r       <= state_s;
            pc_r          <= pc_s;
            trap_r        <= trap_s;
            trap_pc_r     <= trap_pc_s;
            br_count_r    <= br_count_s;
            taken_count_r <= taken_count_s;
        end
    end

    // brUn is funct3[1]: 110/111 compare unsigned, everything else signed.
    assign bus.brUn        = bus.funct3[1];
    assign bus.taken       = taken_s;
    assign bus.pc          = pc_r;
    assign bus.pc_plus4    = pc_plus4_s;
    assign bus.trap        = trap_r;
    assign bus.trap_pc     = trap_pc_r;
    assign bus.br_count    = br_count_r;
    assign bus.taken_count = taken_count_r;

endmodule

// File: tb/tb_branch_pc_unit.sv
// ---------------------------------------------------------------------------
// tb_branch_pc_unit
// Directed-vector bench for branch_pc_unit. Stimulus pushes hand-computed
// expectations (tagged with the cycle they apply to) into a queue; a monitor
// on the falling edge pops and compares them against the DUT outputs.
// ---------------------------------------------------------------------------
module tb_branch_pc_unit;

    localparam int SEL_PC      = 0;
    localparam int SEL_PCP4    = 1;
    localparam int SEL_TAKEN   = 2;
    localparam int SEL_BRUN    = 3;
    localparam int SEL_TRAP    = 4;
    localparam int SEL_TRAPPC  = 5;
    localparam int SEL_BRCNT   = 6;
    localparam int SEL_TKCNT   = 7;

    typedef struct {
        int          cyc;
        int          sel;
        logic [31:0] val;
        string       name;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cycle_cnt = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t q[$];

    branch_pc_unit_if #(.WIDTH(32), .CNT_W(16)) bus ();

    branch_pc_unit #(
        .WIDTH(32),
        .RESET_PC(32'h0000_0000),
        .TRAP_VEC(32'h0000_0100),
        .CNT_W(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [31:0] sample(input int sel);
        case (sel)
            SEL_PC:     return bus.pc;
            SEL_PCP4:   return bus.pc_plus4;
            SEL_TAKEN:  return {31'd0, bus.taken};
            SEL_BRUN:   return {31'd0, bus.brUn};
            SEL_TRAP:   return {31'd0, bus.trap};
            SEL_TRAPPC: return bus.trap_pc;
            SEL_BRCNT:  return {16'd0, bus.br_count};
            SEL_TKCNT:  return {16'd0, bus.taken_count};
            default:    return 32'hDEAD_BEEF;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: compare every expectation due in the current cycle.
    always @(negedge clk) begin : mon
        exp_t e;
        while (q.size() > 0 && q[0].cyc <= cycle_cnt) begin
            e = q.pop_front();
            check(e.name, sample(e.sel), e.val);
        end
    end

    task automatic expect_now(input string name, input int sel, input logic [31:0] v);
        q.push_back('{cyc: cycle_cnt, sel: sel, val: v, name: name});
    endtask

    task automatic expect_next(input string name, input int sel, input logic [31:0] v);
        q.push_back('{cyc: cycle_cnt + 1, sel: sel, val: v, name: name});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic v, input logic st, input logic be, input logic j,
                          input logic jr, input logic [2:0] f3, input logic eq,
                          input logic lt, input logic [31:0] tgt, input logic ack);
        bus.instr_valid = v;
        bus.stall       = st;
        bus.br_en       = be;
        bus.jal         = j;
        bus.jalr        = jr;
        bus.funct3      = f3;
        bus.brEq        = eq;
        bus.brLT        = lt;
        bus.alu_target  = tgt;
        bus.trap_ack    = ack;
    endtask

    initial begin
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 32'h0, 1'b0);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // 1. reset values then sequential stepping
        set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b010, 1'b0, 1'b0, 32'h0, 1'b0);
        expect_now("rst_pc", SEL_PC, 32'h0);
        expect_now("rst_trap", SEL_TRAP, 32'h0);
        expect_now("rst_trap_pc", SEL_TRAPPC, 32'h0);
        expect_now("rst_br_count", SEL_BRCNT, 32'h0);
        expect_now("rst_taken_count", SEL_TKCNT, 32'h0);
        expect_next("seq_pc4", SEL_PC, 32'h4);
        tick();
        expect_next("seq_pc8", SEL_PC, 32'h8);
        tick();
        expect_next("seq_pcC", SEL_PC, 32'hC);
        tick();
        expect_next("seq_pc10", SEL_PC, 32'h10);
        expect_next("seq_br_count", SEL_BRCNT, 32'h0);
        tick();

        // 2. branch decode: beq taken, then bgeu not taken
        set_in(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'b000, 1'b1, 1'b0, 32'h40, 1'b0);
        expect_now("beq_taken", SEL_TAKEN, 32'h1);
        expect_now("beq_brun", SEL_BRUN, 32'h0);
        expect_next("beq_pc", SEL_PC, 32'h40);
        expect_next("beq_br_count", SEL_BRCNT, 32'h1);
        expect_next("beq_taken_count", SEL_TKCNT, 32'h1);
        tick();
        set_in(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'b111, 1'b0, 1'b1, 32'h80, 1'b0);
        expect_now("bgeu_brun", SEL_BRUN, 32'h1);
        expect_now("bgeu_taken", SEL_TAKEN, 32'h0);
        expect_next("bgeu_pc", SEL_PC, 32'h44);
        expect_next("bgeu_br_count", SEL_BRCNT, 32'h2);
        expect_next("bgeu_taken_count", SEL_TKCNT, 32'h1);
        tick();
        // combinational decode with no advance (valid low: pc/counters hold)
        set_in(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'b001, 1'b0, 1'b0, 32'h80, 1'b0);
        expect_now("bne_taken", SEL_TAKEN, 32'h1);
        expect_next("novalid_pc", SEL_PC, 32'h44);
        expect_next("novalid_br_count", SEL_BRCNT, 32'h2);
        tick();
        set_in(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'b100, 1'b0, 1'b0, 32'h80, 1'b0);
        expect_now("blt_nt_taken", SEL_TAKEN, 32'h0);
        expect_now("blt_brun", SEL_BRUN, 32'h0);
        tick();
        set_in(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'b110, 1'b0, 1'b1, 32'h80, 1'b0);
        expect_now("bltu_taken", SEL_TAKEN, 32'h1);
        expect_now("bltu_brun", SEL_BRUN, 32'h1);
        tick();
        set_in(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'b010, 1'b1, 1'b1, 32'h80, 1'b0);
        expect_now("f3_010_taken", SEL_TAKEN, 32'h0);
        tick();
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b1, 1'b0, 32'h80, 1'b0);
        expect_now("nocf_taken", SEL_TAKEN, 32'h0);
        tick();

        // 3. JALR masking, stall hold, priority
        set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'b000, 1'b0, 1'b0, 32'h81, 1'b0);
        expect_now("jalr_taken", SEL_TAKEN, 32'h1);
        expect_now("pc_plus4", SEL_PCP4, 32'h48);
        expect_next("jalr_pc", SEL_PC, 32'h80);
        tick();
        set_in(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 3'b000, 1'b0, 1'b0, 32'h91, 1'b0);
        expect_now("stall_taken", SEL_TAKEN, 32'h1);
        expect_next("stall1_pc", SEL_PC, 32'h80);
        tick();
        expect_next("stall2_pc", SEL_PC, 32'h80);
        tick();
        bus.stall = 1'b0;
        expect_next("unstall_pc", SEL_PC, 32'h90);
        tick();
        set_in(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 3'b010, 1'b0, 1'b0, 32'hA1, 1'b0);
        expect_now("prio_taken", SEL_TAKEN, 32'h1);
        expect_next("prio_pc", SEL_PC, 32'hA0);
        expect_next("prio_br_count", SEL_BRCNT, 32'h2);
        tick();

        // 4. misaligned trap
        set_in(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 32'h20, 1'b0);
        expect_next("jal_pc", SEL_PC, 32'h20);
        tick();
        set_in(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 32'h22, 1'b0);
        expect_next("trap_set", SEL_TRAP, 32'h1);
        expect_next("trap_pc", SEL_TRAPPC, 32'h20);
        expect_next("trap_pc_hold", SEL_PC, 32'h20);
        tick();
        for (int i = 0; i < 3; i++) begin
            set_in(1'b1, 1'b0, 1'b1, 1'b0, (i == 1), 3'b000, 1'b1, 1'b0, 32'h40 + 32'(i), 1'b0);
            expect_next("trap_ignore_pc", SEL_PC, 32'h20);
            expect_next("trap_ignore_trap", SEL_TRAP, 32'h1);
            expect_next("trap_ignore_br_count", SEL_BRCNT, 32'h2);
            tick();
        end
        set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 32'h0, 1'b1);
        expect_next("ack_pc", SEL_PC, 32'h100);
        expect_next("ack_trap", SEL_TRAP, 32'h0);
        expect_next("ack_trap_pc", SEL_TRAPPC, 32'h20);
        tick();
        bus.trap_ack = 1'b0;
        expect_next("run_after_ack", SEL_PC, 32'h104);
        tick();
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 32'h0, 1'b1);
        expect_next("ack_in_run_pc", SEL_PC, 32'h104);
        expect_next("ack_in_run_trap", SEL_TRAP, 32'h0);
        tick();
        set_in(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 32'h22, 1'b0);
        expect_next("nt_misaligned_pc", SEL_PC, 32'h108);
        expect_next("nt_misaligned_trap", SEL_TRAP, 32'h0);
        expect_next("nt_br_count", SEL_BRCNT, 32'h3);
        tick();

        // 5. counter saturation
        set_in(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'b000, 1'b1, 1'b0, 32'h200, 1'b0);
        repeat (65531) tick();
        expect_now("sat_pre_br", SEL_BRCNT, 32'hFFFE);
        expect_now("sat_pre_taken", SEL_TKCNT, 32'hFFFC);
        expect_now("sat_pc", SEL_PC, 32'h200);
        expect_next("sat1_br", SEL_BRCNT, 32'hFFFF);
        expect_next("sat1_taken", SEL_TKCNT, 32'hFFFD);
        tick();
        expect_next("sat2_br", SEL_BRCNT, 32'hFFFF);
        expect_next("sat2_taken", SEL_TKCNT, 32'hFFFE);
        tick();
        expect_next("sat3_br", SEL_BRCNT, 32'hFFFF);
        expect_next("sat3_taken", SEL_TKCNT, 32'hFFFF);
        tick();
        for (int i = 0; i < 2; i++) begin
            expect_next("sat_hold_br", SEL_BRCNT, 32'hFFFF);
            expect_next("sat_hold_taken", SEL_TKCNT, 32'hFFFF);
            tick();
        end

        // PC wrap
        set_in(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 32'hFFFF_FFFC, 1'b0);
        expect_next("jal_top_pc", SEL_PC, 32'hFFFF_FFFC);
        tick();
        set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 32'h0, 1'b0);
        expect_now("wrap_pc_plus4", SEL_PCP4, 32'h0);
        expect_next("wrap_pc", SEL_PC, 32'h0);
        tick();
        expect_next("post_wrap_pc", SEL_PC, 32'h4);
        tick();

        // 6. async reset while trapped
        set_in(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 32'h6, 1'b0);
        expect_next("t6_trap", SEL_TRAP, 32'h1);
        expect_next("t6_trap_pc", SEL_TRAPPC, 32'h4);
        expect_next("t6_pc", SEL_PC, 32'h4);
        tick();
        @(negedge clk);
        #1;
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 32'h0, 1'b0);
        rst = 1'b1;
        #1;
        check("async_rst_pc", bus.pc, 32'h0);
        check("async_rst_trap", {31'd0, bus.trap}, 32'h0);
        check("async_rst_trap_pc", bus.trap_pc, 32'h0);
        check("async_rst_br_count", {16'd0, bus.br_count}, 32'h0);
        tick();
        rst = 1'b0;
        bus.instr_valid = 1'b1;
        expect_now("post_rst_pc", SEL_PC, 32'h0);
        expect_next("post_rst_run_pc", SEL_PC, 32'h4);
        tick();
        bus.instr_valid = 1'b0;

        for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
        @(negedge clk);
        #1;
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expectations left, required 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/branch_pc_unit.md
Name: branch_pc_unit

Overview:
Branch resolution and program-counter stage, directly downstream of the branch comparator.
- Drives brUn to the comparator from funct3, then consumes brEq/brLT to decide taken/not-taken.
- Holds the architectural PC register and selects the next PC: sequential, branch target, JAL target or JALR target.
- Traps misaligned control-flow targets through a small FSM and keeps saturating branch statistics counters.

Parameters:
WIDTH, 32, datapath/PC width in bits
RESET_PC, 32'h0000_0000, PC value loaded on reset
TRAP_VEC, 32'h0000_0100, PC loaded when a trap is acknowledged
CNT_W, 16, width of statistics counters

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-high reset
instr_valid  input  1  current instruction valid; PC may advance
stall  input  1  hold PC this cycle (memory not ready)
br_en  input  1  current instruction is a conditional branch
jal  input  1  current instruction is JAL
jalr  input  1  current instruction is JALR
funct3  input  3  branch funct3 field
brEq  input  1  equality result from comparator
brLT  input  1  less-than result from comparator
alu_target  input  WIDTH  computed target (pc+imm or rs1+imm)
trap_ack  input  1  trap handler accepts trap
brUn  output  1  unsigned-compare select to comparator
pc  output  WIDTH  current PC (registered)
pc_plus4  output  WIDTH  pc + 4 (combinational, return address)
taken  output  1  control transfer this cycle (combinational)
trap  output  1  misaligned-target trap pending (registered)
trap_pc  output  WIDTH  PC of faulting instruction (registered)
br_count  output  CNT_W  conditional branches retired, saturating
taken_count  output  CNT_W  conditional branches taken, saturating

Behaviour:
- Clocking and reset: all state updates on rising clk; rst is asynchronous and active-high.
- Reset values: pc=RESET_PC, trap=0, trap_pc=0, br_count=0, taken_count=0, state=RUN.
- brUn = funct3[1], purely combinational. This makes 110/111 unsigned and 000/001/100/101 signed.
- Branch condition, when br_en=1:
  - 000 beq: taken = brEq.
  - 001 bne: taken = !brEq.
  - 100 blt / 110 bltu: taken = brLT.
  - 101 bge / 111 bgeu: taken = !brLT.
  - 010/011: not taken.
- taken is forced 1 when jal or jalr; taken = 0 when no control-flow instruction.
- Priority when several are asserted: jalr > jal > br_en.
- Target:
  - Branch/JAL target = alu_target.
  - JALR target = alu_target with bit 0 cleared.
- Misaligned target: taken=1 and target[1]=1 (no compressed ISA). Evaluated only when an advance is qualified.
- pc_plus4 = pc + 4, wraps modulo 2^WIDTH (0xFFFF_FFFC -> 0x0000_0000).
- FSM states: RUN, TRAP.
  - RUN, advance condition: instr_valid=1 and stall=0.
  - RUN, no advance: pc holds, counters hold.
  - RUN, advance with misaligned target: pc holds, trap_pc <= pc, trap <= 1, next state TRAP, counters NOT updated.
  - RUN, advance otherwise: pc <= taken ? target : pc_plus4.
  - RUN, advance with br_en=1 (and not jal/jalr): br_count += 1; taken_count += 1 if taken. Both saturate at all-ones (no wrap).
  - TRAP: pc, counters and trap_pc hold; instr_valid, stall and all branch inputs are ignored.
  - TRAP with trap_ack=1: pc <= TRAP_VEC, trap <= 0, next state RUN. The trap_ack cycle does not also advance an instruction.
  - trap_ack in RUN: ignored.
- Latency: the new PC is visible one cycle after the advancing edge. taken and brUn have zero latency (combinational).
- Reset mid-trap: returns immediately to RUN with pc=RESET_PC and trap=0.
- Simultaneous stall and taken: stall wins; the instruction is re-evaluated next cycle.

Test Plan:
1. Reset then step: rst high then low, instr_valid=1, no branches, 3 cycles -> pc 0x0, 0x4, 0x8, 0xC; counters 0.
2. Branch decode: pc=0x10, br_en=1, funct3=000, brEq=1, alu_target=0x40 -> taken=1, brUn=0, next pc=0x40, br_count=1, taken_count=1. Repeat with funct3=111, brLT=1 -> brUn=1, taken=0, next pc=pc+4, br_count=2, taken_count=1.
3. JALR masking and stall:
   - jalr=1, alu_target=0x0000_0081 -> next pc=0x80.
   - Same with stall=1 for 2 cycles -> pc holds, then advances to 0x80 once stall drops.
4. Misaligned trap:
   - pc=0x20, jal=1, alu_target=0x22 -> trap=1, trap_pc=0x20, pc stays 0x20.
   - Inputs are ignored for 3 cycles.
   - trap_ack=1 -> pc=0x100, trap=0, state RUN.
5. Saturation and wrap:
   - Force br_count to 0xFFFE, retire 3 taken branches -> br_count and taken_count stop at 0xFFFF.
   - pc=0xFFFF_FFFC sequential step -> pc=0x0.
6. Async reset during TRAP: assert rst between clock edges while trap=1 -> pc=0x0, trap=0 immediately, without waiting for a clock edge.
